// File: rtl/uart_rx.sv
// uart_rx: oversampling UART receiver with 2-flop input synchronizer.
//
// Ports:
//   clk        system clock, rising edge
//   rst        synchronous reset, active low
//   rx_enb     one-cycle oversampling tick (OS_RATE ticks per bit)
//   rx         asynchronous serial line, idle high
//   rx_rd      consumer read strobe, clears rx_valid
//   rx_data    payload of the last accepted frame (LSB received first)
//   rx_valid   high while rx_data has not been read
//   frame_err  one-cycle pulse when the stop bit samples low
//   overrun    sticky, a good frame arrived while rx_valid was high
//   busy       high whenever the receiver is not idle
module uart_rx #(
    parameter int DATA_BITS = 8,
    parameter int OS_RATE   = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx_enb,
    input  logic                 rx,
    input  logic                 rx_rd,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 frame_err,
    output logic                 overrun,
    output logic                 busy
);

    localparam int TW = $clog2(OS_RATE);
    localparam int BW = $clog2(DATA_BITS + 1);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] START = 2'd1;
    localparam logic [1:0] DATA  = 2'd2;
    localparam logic [1:0] STOP  = 2'd3;

    localparam logic [TW-1:0] T_HALF = TW'(OS_RATE / 2 - 1);
    localparam logic [TW-1:0] T_LAST = TW'(OS_RATE - 1);
    localparam logic [BW-1:0] B_LAST = BW'(DATA_BITS - 1);

    logic [1:0]           state;
    logic [TW-1:0]        tick_cnt;
    logic [BW-1:0]        bit_cnt;
    logic [DATA_BITS-1:0] shift;
    logic                 rx_meta;
    logic                 rx_s;
    // Set after a bad stop bit: STOP then only waits for the line to go high,
    // so a held-low line (break) produces a single frame_err pulse.
    logic                 brk;
    logic [DATA_BITS:0]   shift_in;

    assign busy     = (state != IDLE);
    assign shift_in = {rx_s, shift};

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= IDLE;
            tick_cnt  <= '0;
            bit_cnt   <= '0;
            shift     <= '0;
            rx_meta   <= 1'b1;
            rx_s      <= 1'b1;
            brk       <= 1'b0;
            rx_data   <= '0;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            rx_meta   <= rx;
            rx_s      <= rx_meta;
            frame_err <= 1'b0;

            // Plain read; a completing frame below overrides these in the same cycle.
            if (rx_rd && rx_valid) begin
                rx_valid <= 1'b0;
                overrun  <= 1'b0;
            end

            if (rx_enb) begin
                case (state)
                    IDLE: begin
                        if (!rx_s) begin
                            state    <= START;
                            tick_cnt <= '0;
                        end
                    end
                    START: begin
                        if (tick_cnt == T_HALF) begin
                            if (!rx_s) begin
                                state    <= DATA;
                                tick_cnt <= '0;
                                bit_cnt  <= '0;
                            end else begin
                                state <= IDLE;
                            end
                        end else begin
                            tick_cnt <= tick_cnt + 1'b1;
                        end
                    end
                    DATA: begin
                        if (tick_cnt == T_LAST) begin
                            tick_cnt <= '0;
                            shift    <= shift_in[DATA_BITS:1];
                            if (bit_cnt == B_LAST) begin
                                state   <= STOP;
                                bit_cnt <= '0;
                            end else begin
                                bit_cnt <= bit_cnt + 1'b1;
                            end
                        end else begin
                            tick_cnt <= tick_cnt + 1'b1;
                        end
                    end
                    STOP: begin
                        if (brk) begin
                            if (rx_s) begin
                                state <= IDLE;
                                brk   <= 1'b0;
                            end
                        end else if (tick_cnt == T_LAST) begin
                            tick_cnt <= '0;
                            if (rx_s) begin
                                state <= IDLE;
                                if (!rx_valid || rx_rd) begin
                                    rx_data  <= shift;
                                    rx_valid <= 1'b1;
                                    overrun  <= 1'b0;
                                end else begin
                                    overrun <= 1'b1;
                                end
                            end else begin
                                frame_err <= 1'b1;
                                brk       <= 1'b1;
                            end
                        end else begin
                            tick_cnt <= tick_cnt + 1'b1;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have parameter DATA_BITS, default 8, meaning payload bits per frame (LSB first).
REQ-002 SHALL have parameter OS_RATE, default 16, meaning rx_enb ticks per bit period.
REQ-003 SHALL have port clk  input  1  system clock; all logic on rising edge.
REQ-004 SHALL have port rst  input  1  reset; synchronous, active-low (rst==0 resets on next clk edge).
REQ-005 SHALL have port rx_enb  input  1  single-cycle 16x-baud tick from baud_rate_generator.
REQ-006 SHALL have port rx  input  1  asynchronous serial line, idle high.
REQ-007 SHALL have port rx_rd  input  1  consumer read strobe, one cycle, clears rx_valid.
REQ-008 SHALL have port rx_data  output  DATA_BITS  last accepted frame payload.
REQ-009 SHALL have port rx_valid  output  1  level, high while rx_data unread.
REQ-010 SHALL have port frame_err  output  1  one-cycle pulse on bad stop bit.
REQ-011 SHALL have port overrun  output  1  sticky, frame completed while rx_valid high.
REQ-012 SHALL have port busy  output  1  high in any state other than IDLE.

Function
REQ-013 SHALL pass rx through a 2-flop synchronizer (reset value 1); FSM uses synchronized value rx_s only.
REQ-014 SHALL advance tick counter (width clog2(OS_RATE)) and bit counter only in cycles where rx_enb==1; no state change without rx_enb except rx_rd handling.
REQ-015 SHALL implement states IDLE, START, DATA, STOP.
REQ-016 IDLE: on tick with rx_s==0 -> START, tick counter cleared.
REQ-017 START: at tick OS_RATE/2 (8th tick, mid start bit) rx_s==0 -> DATA, counters cleared; rx_s==1 -> IDLE (false start, no output change).
REQ-018 DATA: every OS_RATE ticks sample rx_s into shift register MSB side, shifting right (LSB first); after DATA_BITS samples -> STOP.
REQ-019 STOP: OS_RATE ticks after last data sample, sample rx_s; ==1 -> frame good, -> IDLE.
REQ-020 Good frame: if rx_valid==0 or rx_rd==1 same cycle, load rx_data, rx_valid=1 next cycle; else keep old rx_data, discard new, set overrun.
REQ-021 Stop sample ==0: frame_err=1 for exactly one cycle, rx_data/rx_valid unchanged, remain in STOP until a tick with rx_s==1, then -> IDLE.
REQ-022 rx_rd with rx_valid==1 and no simultaneous completion: rx_valid=0 and overrun=0 next cycle; rx_rd with rx_valid==0 has no effect.
REQ-023 Simultaneous rx_rd and good completion: new data loaded, rx_valid stays 1, overrun not set (cleared if previously set).
REQ-024 Latency: rx_valid/frame_err assert the cycle after the rx_enb tick that samples stop bit.
REQ-025 Line held low continuously (break) SHALL yield frame_err once, then wait in STOP; no repeated pulses.

Reset
REQ-026 On rst==0 at clk edge: state=IDLE, counters=0, shift register=0, rx_data=0, rx_valid=0, frame_err=0, overrun=0, busy=0, synchronizer flops=1.
REQ-027 Reset mid-frame SHALL abort the frame with no output pulse; reception resumes on next falling edge after rst==1.
REQ-028 rx_enb pulses during reset SHALL be ignored.

Verification
REQ-029 Frame 0x55 (start, 10101010 LSB-first, stop=1), rx_enb every 326 clk -> rx_data=0x55, rx_valid=1, frame_err=0, overrun=0.
REQ-030 rx low for 5 ticks then high -> returns IDLE, busy drops, rx_valid stays 0.
REQ-031 Frame 0xA3 with stop=0 -> frame_err one-cycle pulse, rx_valid 0; then line high 1 bit, frame 0x3C -> rx_data=0x3C, rx_valid=1.
REQ-032 Frames 0x11 then 0x22, no rx_rd -> rx_data=0x11, overrun=1; rx_rd -> rx_valid=0, overrun=0.
REQ-033 rx_rd asserted in completion cycle of second frame 0x22 -> rx_data=0x22, rx_valid=1, overrun=0.
REQ-034 rst=0 during bit 4 of frame 0xFF -> all outputs reset values, no rx_valid; next frame 0x81 received correctly.
